// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide sequencer.
// XLEN lives here so the interface, datapath and helper functions agree on width.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // MULHSU deliberately absent: its rs2 operand is unsigned.
  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic isSigned);
    return (isSigned && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage handshake between the pipeline (master) and the mul/div sequencer (slave).
interface muldiv_ctrl_if;
  import muldiv_pkg::*;

  logic            i_valid;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic            i_flush;
  logic            o_stall;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_op, i_rs1_data, i_rs2_data, i_flush,
    input  o_stall, o_busy, o_done, o_result
  );

  modport slave (
    input  i_valid, i_op, i_rs1_data, i_rs2_data, i_flush,
    output o_stall, o_busy, o_done, o_result
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M sequencer: shift-add multiply / restoring divide on operand
// magnitudes, one bit per cycle, with sign correction folded into the last step.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  muldiv_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q;
  logic [CNT_W-1:0]  counter_q;
  muldiv_op_e        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   operand_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   pend_q;
  logic [XLEN-1:0]   result_q;

  muldiv_op_e        opIn;
  logic [XLEN-1:0]   aMag, bMag, fastResult;
  logic              aNeg, bNeg, negIn, divZero, overflow, fastPath;

  assign opIn       = muldiv_op_e'(bus.i_op);
  assign aMag       = magnitude(bus.i_rs1_data, is_signed_a(opIn));
  assign bMag       = magnitude(bus.i_rs2_data, is_signed_b(opIn));
  assign aNeg       = is_signed_a(opIn) & bus.i_rs1_data[XLEN-1];
  assign bNeg       = is_signed_b(opIn) & bus.i_rs2_data[XLEN-1];
  assign negIn      = is_rem(opIn) ? aNeg : (aNeg ^ bNeg);
  assign divZero    = (bus.i_rs2_data == '0);
  assign overflow   = is_signed_b(opIn) && (bus.i_rs1_data == INT_MIN) && (bus.i_rs2_data == '1);
  assign fastPath   = is_div(opIn) && (divZero || overflow);
  assign fastResult = divZero ? (is_rem(opIn) ? bus.i_rs1_data : '1)
                              : (is_rem(opIn) ? '0 : INT_MIN);

  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divShift;
  logic [XLEN:0]     divDiff;
  logic              divOk;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   rem_d;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   final_d;

  // A set top bit in divShift means it already exceeds any XLEN-bit divisor.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    divShift = {rem_q, acc_q[XLEN-1]};
    divDiff  = divShift - {1'b0, operand_q};
    divOk    = divShift[XLEN] | ~divDiff[XLEN];
    acc_d    = {mulSum, acc_q[XLEN-1:1]};
    rem_d    = rem_q;
    if (is_div(op_q)) begin
      acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], divOk};
      rem_d = divOk ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
    end
    product = cond_neg_wide(acc_d, neg_q);
    final_d = product[XLEN-1:0];
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: final_d = product[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_d = cond_neg(acc_d[XLEN-1:0], neg_q);
      OP_REM, OP_REMU:              final_d = cond_neg(rem_d, neg_q);
      default:                      final_d = product[XLEN-1:0];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      operand_q <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      pend_q    <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid && !bus.i_flush) begin
            op_q      <= opIn;
            neg_q     <= negIn;
            counter_q <= '0;
            rem_q     <= '0;
            if (fastPath) begin
              pend_q  <= fastResult;
              state_q <= DONE;
            end else begin
              // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
              operand_q <= is_div(opIn) ? bMag : aMag;
              acc_q     <= {{XLEN{1'b0}}, (is_div(opIn) ? aMag : bMag)};
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.i_flush) begin
            state_q <= IDLE;
          end else begin
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            counter_q <= counter_q + CNT_W'(1);
            if (counter_q == CNT_W'(XLEN-1)) begin
              pend_q  <= final_d;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (!bus.i_flush) result_q <= pend_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A flush in the DONE cycle hides the pending result and keeps the old one visible.
  assign bus.o_busy   = (state_q != IDLE);
  assign bus.o_stall  = ((state_q == IDLE) && bus.i_valid && !bus.i_flush) || (state_q == CALC);
  assign bus.o_done   = (state_q == DONE) && !bus.i_flush;
  assign bus.o_result = ((state_q == DONE) && !bus.i_flush) ? pend_q : result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: literal expectations per operation plus a
// cycle-level reference model built from plain 64-bit arithmetic.
module tb_muldiv_ctrl;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  muldiv_ctrl_if bus();

  muldiv_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     ia, ib;
    logic   ovf;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MUL:    begin p = ua * ub; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic modelFast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference model: countdown of remaining CALC cycles plus pending/committed results.
  int          mRemain;
  logic        mInDone;
  logic [31:0] mPend;
  logic [31:0] mResult;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRemain <= 0;
      mInDone <= 1'b0;
      mPend   <= 32'd0;
      mResult <= 32'd0;
    end else if (mInDone) begin
      if (!bus.i_flush) mResult <= mPend;
      mInDone <= 1'b0;
    end else if (mRemain > 0) begin
      if (bus.i_flush) begin
        mRemain <= 0;
      end else begin
        mRemain <= mRemain - 1;
        if (mRemain == 1) mInDone <= 1'b1;
      end
    end else if (bus.i_valid && !bus.i_flush) begin
      mPend <= modelResult(bus.i_op, bus.i_rs1_data, bus.i_rs2_data);
      if (modelFast(bus.i_op, bus.i_rs1_data, bus.i_rs2_data)) mInDone <= 1'b1;
      else mRemain <= 32;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cmp busy", 32'(bus.o_busy), 32'((mRemain > 0) || mInDone));
      checkOutput("cmp stall", 32'(bus.o_stall),
                  32'((mRemain > 0) || (mRemain == 0 && !mInDone && bus.i_valid && !bus.i_flush)));
      checkOutput("cmp done", 32'(bus.o_done), 32'(mInDone && !bus.i_flush));
      checkOutput("cmp result", bus.o_result, (mInDone && !bus.i_flush) ? mPend : mResult);
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.i_valid    = 1'b1;
    bus.i_op       = op;
    bus.i_rs1_data = a;
    bus.i_rs2_data = b;
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input int expStall, input int expLat);
    int cyc = 0;
    int stallCnt = 0;
    bit seen = 0;
    applyStimulus(op, a, b);
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.o_stall) stallCnt++;
      if (bus.o_done) seen = 1;
    end
    checkOutput({name, " done seen"}, 32'(seen), 32'd1);
    checkOutput({name, " result"}, bus.o_result, expRes);
    checkOutput({name, " stall cycles"}, 32'(stallCnt), 32'(expStall));
    checkOutput({name, " done latency"}, 32'(cyc - 1), 32'(expLat));
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int doneCnt;
    rst_n          = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_op       = 3'd0;
    bus.i_rs1_data = 32'd0;
    bus.i_rs2_data = 32'd0;
    bus.i_flush    = 1'b0;

    checkOutput("model MULHSU", modelResult(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    checkOutput("model DIV neg", modelResult(DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    checkOutput("model REM ovf", modelResult(REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(bus.o_busy), 32'd0);
    checkOutput("reset done", 32'(bus.o_done), 32'd0);
    checkOutput("reset result", bus.o_result, 32'd0);
    checkOutput("reset stall", 32'(bus.o_stall), 32'd0);
    rst_n = 1'b1;

    runOp("MUL 7*-3",        MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 33);
    runOp("MULHU -1*-1",     MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33);
    runOp("MULHSU -1*max",   MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 33);
    runOp("MULH -1*-1",      MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33, 33);
    runOp("DIV 5/0",         DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1, 1);
    runOp("REMU 5/0",        REMU,   32'd5,          32'd0,         32'd5,         1, 1);
    runOp("DIV ovf",         DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    runOp("REM ovf",         REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 1);
    runOp("DIV -7/2",        DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 33);
    runOp("REM -7/2",        REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 33);
    runOp("DIVU 100/7",      DIVU,   32'd100,        32'd7,         32'd14,        33, 33);
    runOp("REMU 100/7",      REMU,   32'd100,        32'd7,         32'd2,         33, 33);

    // Squash in the tenth CALC cycle; the previous result (2) must survive.
    applyStimulus(MUL, 32'h0000_1234, 32'h0000_0010);
    repeat (10) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    @(negedge clk);
    checkOutput("flush calc busy", 32'(bus.o_busy), 32'd1);
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush idle stall", 32'(bus.o_stall), 32'd0);
    checkOutput("flush idle busy", 32'(bus.o_busy), 32'd0);
    checkOutput("flush idle done", 32'(bus.o_done), 32'd0);
    checkOutput("flush idle result", bus.o_result, 32'd2);
    doneCnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) doneCnt++;
    end
    checkOutput("flush no done pulse", 32'(doneCnt), 32'd0);
    runOp("DIVU 9/3", DIVU, 32'd9, 32'd3, 32'd3, 33, 33);

    applyStimulus(DIV, 32'd5, 32'd0);
    @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    @(negedge clk);
    checkOutput("flush done pulse", 32'(bus.o_done), 32'd0);
    checkOutput("flush done result", bus.o_result, 32'd3);
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    checkOutput("after flush done result", bus.o_result, 32'd3);
    checkOutput("after flush done busy", 32'(bus.o_busy), 32'd0);

    applyStimulus(MUL, 32'h0000_0055, 32'h0000_0077);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(bus.o_busy), 32'd0);
    checkOutput("async reset done", 32'(bus.o_done), 32'd0);
    checkOutput("async reset result", bus.o_result, 32'd0);
    bus.i_valid = 1'b0;
    #1;
    checkOutput("async reset stall", 32'(bus.o_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("MUL 3*4", MUL, 32'd3, 32'd4, 32'd12, 33, 33);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
